// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch queue between the icache and the decoder.
// Issues sequential fetch requests, holds up to DEPTH in-flight/filled
// entries in program order, and handles redirects by freeing all entries and
// counting the responses still owed for the flushed requests.
// Optional feature: define IFETCH_BYPASS_EN to forward a response straight
// to the decoder in the same cycle when it fills the head entry.
module ifetch_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [XLEN-1:0] reset_adr_i,
   input  logic            branch_v_q_i,
   input  logic [XLEN-1:0] pc_data_q_i,
   output logic            icache_req_v_o,
   output logic [XLEN-1:0] icache_adr_o,
   input  logic            icache_req_rdy_i,
   input  logic            icache_rsp_v_i,
   input  logic [31:0]     icache_instr_i,
   output logic            instr_v_o,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] pc_o,
   input  logic            dec_rdy_i
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = CW + 1;

   typedef enum logic {BOOT, RUN} state_t;

   state_t          state;
   state_t          state_next;
   logic [XLEN-1:0] fetch_pc_q;
   logic [CW-1:0]   occupancy;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   unfilled_cnt;
   logic [PW-1:0]   head_ptr;
   logic [PW-1:0]   tail_ptr;
   logic [PW-1:0]   fill_ptr;
   logic [DEPTH-1:0] filled;
   logic [DEPTH-1:0] filled_next;
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [31:0]     instr_mem [DEPTH];

   logic            running;
   logic [SW-1:0]   load;
   logic [SW-1:0]   owed;
   logic [CW-1:0]   flush_drop;
   logic            req_v;
   logic            req_fire;
   logic            rsp_drop;
   logic            rsp_fill;
   logic            head_v;
   logic [31:0]     head_instr;
   logic            pop;

   // Next-state, request/response/pop decisions and the outputs.
   // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
   always_comb begin
      state_next  = state;
      running     = (state == RUN);
      load        = {1'b0, occupancy} + {1'b0, drop_cnt};
      owed        = {1'b0, drop_cnt} + {1'b0, unfilled_cnt};
      flush_drop  = CW'(owed - SW'(icache_rsp_v_i && (owed != '0)));
      req_v       = running & ~branch_v_q_i & (load < SW'(DEPTH));
      req_fire    = req_v & icache_req_rdy_i;
      rsp_drop    = running & ~branch_v_q_i & icache_rsp_v_i & (drop_cnt != '0);
      rsp_fill    = running & ~branch_v_q_i & icache_rsp_v_i & (drop_cnt == '0)
                    & (unfilled_cnt != '0);
      head_instr  = instr_mem[head_ptr];
      head_v      = running & ~branch_v_q_i & (occupancy != '0) & filled[head_ptr];
`ifdef IFETCH_BYPASS_EN
      // The oldest unfilled entry is the head here, so this response fills it.
      if (running && !branch_v_q_i && (occupancy != '0) && !filled[head_ptr]
          && (drop_cnt == '0) && icache_rsp_v_i) begin
         head_v     = 1'b1;
         head_instr = icache_instr_i;
      end
`endif
      pop         = head_v & dec_rdy_i;
      filled_next = filled;
      if (rsp_fill) filled_next[fill_ptr] = 1'b1;
      if (pop)      filled_next[head_ptr] = 1'b0;

      case (state)
         BOOT:    state_next = RUN;
         default: state_next = RUN;
      endcase

      icache_req_v_o = req_v;
      icache_adr_o   = fetch_pc_q;
      instr_v_o      = head_v;
      instr_o        = head_v ? head_instr : '0;
      pc_o           = head_v ? pc_mem[head_ptr] : '0;
   end

   // FSM state register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= BOOT;
      else          state <= state_next;
   end

   // Fetch PC, occupancy/drop counters, pointers and fill flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q   <= '0;
         occupancy    <= '0;
         drop_cnt     <= '0;
         unfilled_cnt <= '0;
         head_ptr     <= '0;
         tail_ptr     <= '0;
         fill_ptr     <= '0;
         filled       <= '0;
      end else if (state == BOOT) begin
         fetch_pc_q <= reset_adr_i;
      end else if (branch_v_q_i) begin
         fetch_pc_q   <= pc_data_q_i;
         occupancy    <= '0;
         drop_cnt     <= flush_drop;
         unfilled_cnt <= '0;
         head_ptr     <= '0;
         tail_ptr     <= '0;
         fill_ptr     <= '0;
         filled       <= '0;
      end else begin
         occupancy    <= occupancy + CW'(req_fire) - CW'(pop);
         unfilled_cnt <= unfilled_cnt + CW'(req_fire) - CW'(rsp_fill);
         filled       <= filled_next;
         if (rsp_drop) drop_cnt <= drop_cnt - 1'b1;
         if (req_fire) begin
            tail_ptr   <= tail_ptr + 1'b1;
            fetch_pc_q <= fetch_pc_q + XLEN'(4);
         end
         if (rsp_fill) fill_ptr <= fill_ptr + 1'b1;
         if (pop)      head_ptr <= head_ptr + 1'b1;
      end
   end

   // Entry payload storage.
   // NOTE: payload arrays are not reset; filled flags and output gating make stale data invisible.
   always_ff @(posedge clk) begin
      if (req_fire) pc_mem[tail_ptr]    <= fetch_pc_q;
      if (rsp_fill) instr_mem[fill_ptr] <= icache_instr_i;
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed scenarios against a queue-level model of the
// fetch queue, compared every cycle, plus literal expectations per scenario.
module tb_ifetch_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
`ifdef IFETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [XLEN-1:0] reset_adr_i = '0;
   logic            branch_v_q_i = 1'b0;
   logic [XLEN-1:0] pc_data_q_i = '0;
   logic            icache_req_v_o;
   logic [XLEN-1:0] icache_adr_o;
   logic            icache_req_rdy_i = 1'b0;
   logic            icache_rsp_v_i = 1'b0;
   logic [31:0]     icache_instr_i = '0;
   logic            instr_v_o;
   logic [31:0]     instr_o;
   logic [XLEN-1:0] pc_o;
   logic            dec_rdy_i = 1'b0;

   ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .reset_adr_i(reset_adr_i),
      .branch_v_q_i(branch_v_q_i), .pc_data_q_i(pc_data_q_i),
      .icache_req_v_o(icache_req_v_o), .icache_adr_o(icache_adr_o),
      .icache_req_rdy_i(icache_req_rdy_i), .icache_rsp_v_i(icache_rsp_v_i),
      .icache_instr_i(icache_instr_i), .instr_v_o(instr_v_o),
      .instr_o(instr_o), .pc_o(pc_o), .dec_rdy_i(dec_rdy_i)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit rsp_en = 1'b0;
   bit rsp_extra = 1'b0;

   logic [31:0] pending[$];
   logic [31:0] acc_log[$];
   int          acc_cyc[$];
   logic [31:0] pop_pc[$];
   logic [31:0] pop_instr[$];
   int          pop_cyc[$];

   // Model: entries as queues in program order, plus owed-response count.
   bit          m_boot = 1'b1;
   logic [31:0] m_pc = '0;
   int          m_drop = 0;
   logic [31:0] q_pc[$];
   logic [31:0] q_instr[$];
   bit          q_filled[$];

   function automatic logic [31:0] hash(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle compare against the model, then advance the model.
   always @(negedge clk) begin : compare
      bit          e_req;
      bit          e_iv;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      int          unf;
      bit          found;
      if (!reset_n) begin
         check("rst_req_v", icache_req_v_o, 0);
         check("rst_adr", icache_adr_o, 0);
         check("rst_instr_v", instr_v_o, 0);
         check("rst_instr", instr_o, 0);
         check("rst_pc", pc_o, 0);
         m_boot = 1'b1; m_pc = '0; m_drop = 0;
         q_pc.delete(); q_instr.delete(); q_filled.delete();
      end else begin
         e_req = !m_boot && !branch_v_q_i && (q_pc.size() + m_drop < DEPTH);
         e_iv = 1'b0; e_instr = '0; e_pc = '0;
         if (!m_boot && !branch_v_q_i && q_pc.size() > 0) begin
            e_pc = q_pc[0];
            if (q_filled[0]) begin
               e_iv = 1'b1; e_instr = q_instr[0];
            end
`ifdef IFETCH_BYPASS_EN
            else if (m_drop == 0 && icache_rsp_v_i) begin
               e_iv = 1'b1; e_instr = icache_instr_i;
            end
`endif
         end
         check("req_v", icache_req_v_o, e_req);
         if (e_req) check("req_adr", icache_adr_o, m_pc);
         check("instr_v", instr_v_o, e_iv);
         if (e_iv) begin
            check("instr", instr_o, e_instr);
            check("pc", pc_o, e_pc);
         end
         if (icache_req_v_o && icache_req_rdy_i) begin
            acc_log.push_back(icache_adr_o); acc_cyc.push_back(cyc);
         end
         if (instr_v_o && dec_rdy_i) begin
            pop_pc.push_back(pc_o); pop_instr.push_back(instr_o); pop_cyc.push_back(cyc);
         end
         if (e_req && icache_req_rdy_i) pending.push_back(m_pc);
         if (m_boot) begin
            m_boot = 1'b0;
            m_pc = reset_adr_i;
         end else if (branch_v_q_i) begin
            unf = 0;
            foreach (q_filled[i]) if (!q_filled[i]) unf++;
            m_drop = m_drop + unf;
            if (icache_rsp_v_i && m_drop > 0) m_drop--;
            q_pc.delete(); q_instr.delete(); q_filled.delete();
            m_pc = pc_data_q_i;
         end else begin
            if (icache_rsp_v_i) begin
               if (m_drop > 0) m_drop--;
               else begin
                  found = 1'b0;
                  foreach (q_filled[i]) if (!found && !q_filled[i]) begin
                     q_filled[i] = 1'b1; q_instr[i] = icache_instr_i; found = 1'b1;
                  end
               end
            end
            if (e_iv && dec_rdy_i) begin
               void'(q_pc.pop_front()); void'(q_instr.pop_front()); void'(q_filled.pop_front());
            end
            if (e_req && icache_req_rdy_i) begin
               q_pc.push_back(m_pc); q_instr.push_back('0); q_filled.push_back(1'b0);
               m_pc = m_pc + 32'd4;
            end
         end
      end
   end

   // Advance one cycle and drive the icache response for the new cycle.
   task automatic tick;
      @(posedge clk);
      #1;
      if (!reset_n) begin
         pending.delete();
         icache_rsp_v_i = 1'b0; icache_instr_i = '0;
      end else if (rsp_extra) begin
         icache_rsp_v_i = 1'b1; icache_instr_i = 32'hDEAD_BEEF;
      end else if (rsp_en && pending.size() > 0) begin
         icache_rsp_v_i = 1'b1; icache_instr_i = hash(pending.pop_front());
      end else begin
         icache_rsp_v_i = 1'b0; icache_instr_i = '0;
      end
   endtask

   task automatic do_reset;
      reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
   endtask

   task automatic wait_acc(input int target, input int budget);
      int n = 0;
      while (acc_log.size() < target && n < budget) begin tick(); n++; end
      check("wait_acc", acc_log.size() >= target, 1);
   endtask

   task automatic wait_pop(input int target, input int budget);
      int n = 0;
      while (pop_pc.size() < target && n < budget) begin tick(); n++; end
      check("wait_pop", pop_pc.size() >= target, 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int a0;
      int p0;
      // Boot sequence and bypass latency.
      reset_adr_i = 32'h8000_0000; icache_req_rdy_i = 1'b1; dec_rdy_i = 1'b1; rsp_en = 1'b1;
      do_reset();
      a0 = acc_log.size(); p0 = pop_pc.size();
      wait_pop(p0 + 3, 30);
      check("boot_adr0", acc_log[a0],     32'h8000_0000);
      check("boot_adr1", acc_log[a0 + 1], 32'h8000_0004);
      check("boot_adr2", acc_log[a0 + 2], 32'h8000_0008);
      check("boot_pc0",  pop_pc[p0],      32'h8000_0000);
      check("boot_pc1",  pop_pc[p0 + 1],  32'h8000_0004);
      check("boot_pc2",  pop_pc[p0 + 2],  32'h8000_0008);
      check("bypass_lat", pop_cyc[p0] - acc_cyc[a0], LAT);

      // Backpressure, spurious response, redirect with a filled head (mid-run reset first).
      reset_adr_i = 32'h0000_1000; dec_rdy_i = 1'b0;
      do_reset();
      a0 = acc_log.size(); p0 = pop_pc.size();
      wait_acc(a0 + 4, 20);
      repeat (4) tick();
      check("bp_count", acc_log.size() - a0, 4);
      check("bp_req_off", icache_req_v_o, 0);
      rsp_extra = 1'b1; tick(); rsp_extra = 1'b0; tick();
      dec_rdy_i = 1'b1; tick(); dec_rdy_i = 1'b0;
      check("bp_req_resume", icache_req_v_o, 1);
      tick(); tick();
      check("bp_count2", acc_log.size() - a0, 5);
      check("bp_req_off2", icache_req_v_o, 0);
      check("bp_pop_pc", pop_pc[p0], 32'h0000_1000);
      check("bp_pop_instr", pop_instr[p0], hash(32'h0000_1000));
      dec_rdy_i = 1'b1; branch_v_q_i = 1'b1; pc_data_q_i = 32'h0000_4000;
      #1;
      check("br_hold_instr_v", instr_v_o, 0);
      check("br_hold_req_v", icache_req_v_o, 0);
      tick(); branch_v_q_i = 1'b0;
      p0 = pop_pc.size();
      wait_pop(p0 + 1, 20);
      check("br_full_pc", pop_pc[p0], 32'h0000_4000);

      // Flush of three unfilled requests.
      reset_adr_i = 32'h0000_2000; rsp_en = 1'b0; dec_rdy_i = 1'b1; icache_req_rdy_i = 1'b1;
      do_reset();
      a0 = acc_log.size(); p0 = pop_pc.size();
      wait_acc(a0 + 3, 20);
      icache_req_rdy_i = 1'b0; branch_v_q_i = 1'b1; pc_data_q_i = 32'h0000_0100;
      tick();
      branch_v_q_i = 1'b0; icache_req_rdy_i = 1'b1; rsp_en = 1'b1;
      wait_pop(p0 + 1, 30);
      check("flush_adr", acc_log[a0 + 3], 32'h0000_0100);
      check("flush_pc", pop_pc[p0], 32'h0000_0100);
      check("flush_instr", pop_instr[p0], hash(32'h0000_0100));

      // Redirect coinciding with a response, target at the top of the address space.
      reset_adr_i = 32'h0000_3000; rsp_en = 1'b0;
      do_reset();
      a0 = acc_log.size(); p0 = pop_pc.size();
      wait_acc(a0 + 2, 20);
      icache_req_rdy_i = 1'b0; rsp_en = 1'b1;
      tick();
      rsp_en = 1'b0; branch_v_q_i = 1'b1; pc_data_q_i = 32'hFFFF_FFFC;
      #1;
      check("br_rsp_instr_v", instr_v_o, 0);
      tick();
      branch_v_q_i = 1'b0; icache_req_rdy_i = 1'b1; rsp_en = 1'b1;
      wait_pop(p0 + 2, 30);
      check("wrap_adr0", acc_log[a0 + 2], 32'hFFFF_FFFC);
      check("wrap_adr1", acc_log[a0 + 3], 32'h0000_0000);
      check("wrap_pc0", pop_pc[p0], 32'hFFFF_FFFC);
      check("wrap_pc1", pop_pc[p0 + 1], 32'h0000_0000);
      check("wrap_instr1", pop_instr[p0 + 1], hash(32'h0000_0000));

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter XLEN, default 32, address/PC width in bits.
REQ-002 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, >= 2.
REQ-003 clk  in  1  single core clock; all state on rising edge.
REQ-004 reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 reset_adr_i  in  XLEN  boot PC, sampled in BOOT state.
REQ-006 branch_v_q_i  in  1  redirect/flush request from EXE.
REQ-007 pc_data_q_i  in  XLEN  redirect target, valid with branch_v_q_i.
REQ-008 icache_req_v_o  out  1  fetch request valid.
REQ-009 icache_adr_o  out  XLEN  fetch address, valid with icache_req_v_o.
REQ-010 icache_req_rdy_i  in  1  icache accepts request this cycle.
REQ-011 icache_rsp_v_i  in  1  in-order response valid, latency >= 1 cycle.
REQ-012 icache_instr_i  in  32  response instruction.
REQ-013 instr_v_o  out  1  head entry valid toward DEC.
REQ-014 instr_o  out  32  head instruction.
REQ-015 pc_o  out  XLEN  head PC.
REQ-016 dec_rdy_i  in  1  DEC consumes head when instr_v_o & dec_rdy_i.

Function
REQ-017 FSM states BOOT, RUN; BOOT -> RUN unconditionally after one cycle; fetch_pc_q <= reset_adr_i on that transition; no request in BOOT.
REQ-018 Entry = {pc, instr, filled}; occupancy = reserved entries; drop_cnt = responses still owed for flushed requests.
REQ-019 RUN: icache_req_v_o = ~branch_v_q_i & (occupancy + drop_cnt < DEPTH), using registered counts; icache_adr_o = fetch_pc_q.
REQ-020 On req_v & req_rdy: reserve tail entry with pc = fetch_pc_q, filled = 0; fetch_pc_q += 4 modulo 2^XLEN.
REQ-021 On rsp_v with drop_cnt != 0: decrement drop_cnt, discard data.
REQ-022 On rsp_v with drop_cnt == 0: write instr into oldest unfilled entry, set filled.
REQ-023 rsp_v with drop_cnt == 0 and no unfilled entry: ignored, no state change.
REQ-024 instr_v_o = head reserved & filled & ~branch_v_q_i; pop on instr_v_o & dec_rdy_i.
REQ-025 branch_v_q_i: all entries freed; drop_cnt <= drop_cnt + unfilled entries - (rsp_v ? 1 : 0) (rsp consumed as a drop); fetch_pc_q <= pc_data_q_i; no request, no pop that cycle; first redirected request next cycle.
REQ-026 Branch in BOOT ignored; BOOT target wins.
REQ-027 Reserve + fill + pop in same cycle all permitted; counters updated consistently.
REQ-028 Full (occupancy + drop_cnt == DEPTH): no request; slot freed by pop/drop usable next cycle.
REQ-029 drop_cnt, occupancy width clog2(DEPTH)+1; never exceed DEPTH.

Reset
REQ-030 While reset_n low: state BOOT, occupancy 0, drop_cnt 0, all filled 0, fetch_pc_q 0, pointers 0.
REQ-031 Outputs in reset: icache_req_v_o 0, icache_adr_o 0, instr_v_o 0, instr_o 0, pc_o 0.
REQ-032 Reset mid-operation discards all entries and owed responses; icache shares reset_n.

Configuration
REQ-033 Macro IFETCH_BYPASS_EN defined: if head reserved & unfilled, drop_cnt == 0, rsp_v high, then instr_v_o = 1, instr_o = icache_instr_i same cycle; pop with dec_rdy_i, else entry filled normally.
REQ-034 Macro undefined: response visible on instr_v_o no earlier than the cycle after rsp_v.

Verification
REQ-035 Boot: reset_adr_i=0x8000_0000, req_rdy=1, 1-cycle rsp, dec_rdy=1 -> addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 in order; pc_o matches.
REQ-036 Backpressure: DEPTH=4, dec_rdy=0 -> exactly 4 requests then req_v=0; dec_rdy=1 one cycle -> 1 pop, 1 new request next cycle.
REQ-037 Flush: 3 outstanding unfilled, branch to 0x100 -> drop_cnt=3, next 3 responses discarded, next request adr 0x100, first instr_v_o carries pc_o=0x100.
REQ-038 Branch with simultaneous rsp_v and 2 unfilled -> drop_cnt=1, instr_v_o=0 that cycle.
REQ-039 Wrap: fetch_pc_q=0xFFFF_FFFC -> next request adr 0x0000_0000.
REQ-040 Bypass: empty queue, rsp same cycle as head fill, dec_rdy=1 -> with IFETCH_BYPASS_EN instr_v_o=1 that cycle; without, one cycle later.
